if_id_hazard_ctrl: RTL and testbench

IF_ID_HAZARD_CTRL -- requirements
Module: if_id_hazard_ctrl

---
 rtl/if_id_hazard_ctrl_pkg.sv | 24 ++
 rtl/if_id_hazard_ctrl_if.sv | 26 ++
 rtl/if_id_hazard_ctrl_lu.sv | 17 +
 rtl/if_id_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/if_id_hazard_ctrl_pkg.sv
// if_id_hazard_ctrl_pkg: shared opcodes, NOP word, ID mux select encodings and FSM states
// No ports; imported by the hazard controller, its interface users and the load-use detector.
package if_id_hazard_ctrl_pkg;
    localparam logic [5:0]  OP_BNE = 6'b000101;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    typedef enum logic [1:0] {
        IRSRC_PASS = 2'b00,
        IRSRC_NOP  = 2'b01,
        IRSRC_BNE  = 2'b10
    } irsrc_e;
    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction
    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[25:21];
    endfunction
    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[20:16];
    endfunction
endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// if_id_hazard_ctrl_if: pipeline-side signal bundle of the IF/ID hazard controller
// Inputs to the controller: if_instr, if_valid, ex_mem_read, ex_rt, br_valid, br_taken.
// Outputs from the controller: id_instr, irsrc_rf, pc_write, ifid_write, stall_cnt, br_err.
// master = pipeline/stimulus side, slave = controller side.
interface if_id_hazard_ctrl_if #(parameter int STALL_CNT_W = 16);
    logic [31:0]            if_instr;
    logic                   if_valid;
    logic                   ex_mem_read;
    logic [4:0]             ex_rt;
    logic                   br_valid;
    logic                   br_taken;
    logic [31:0]            id_instr;
    logic [1:0]             irsrc_rf;
    logic                   pc_write;
    logic                   ifid_write;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   br_err;
    modport master (
        output if_instr, if_valid, ex_mem_read, ex_rt, br_valid, br_taken,
        input  id_instr, irsrc_rf, pc_write, ifid_write, stall_cnt, br_err
    );
    modport slave (
        input  if_instr, if_valid, ex_mem_read, ex_rt, br_valid, br_taken,
        output id_instr, irsrc_rf, pc_write, ifid_write, stall_cnt, br_err
    );
endinterface

// File: rtl/if_id_hazard_ctrl_lu.sv
// load_use_detect: combinational load-use hazard detection against the instruction in ID
// ex_mem_read_i: EX holds a load; ex_rt_i: its destination; id_instr_i: IF/ID instruction; lu_o: hazard.
module load_use_detect
    import if_id_hazard_ctrl_pkg::*;
(
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rt_i,
    input  logic [31:0] id_instr_i,
    output logic        lu_o
);
    // Only rs/rt matter here; the remaining bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{id_instr_i[31:26], id_instr_i[15:0]};
    // $zero never carries a real dependency, so a load to r0 cannot stall.
    assign lu_o = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                  (ex_rt_i == rs_of(id_instr_i) || ex_rt_i == rt_of(id_instr_i));
endmodule

// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: IF/ID register with load-use bubbles and BNE resolve-wait control
// clk, rst: clock and synchronous active-high reset.
// bus (slave): IF instruction/valid, EX load info, branch resolution in;
//              id_instr, irsrc_rf, pc_write, ifid_write, stall_cnt, br_err out.
module if_id_hazard_ctrl
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int BR_TIMEOUT  = 15,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    if_id_hazard_ctrl_if.slave bus
);
    localparam int TW = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;

    state_e                 state_q, state_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [31:0]            id_q, id_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   err_q, err_d;
    logic                   lu, flush, tmo_hit, pc_we, ifid_we;
    irsrc_e                 irsrc;

    load_use_detect u_lu (
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_rt_i       (bus.ex_rt),
        .id_instr_i    (id_q),
        .lu_o          (lu)
    );

    assign tmo_hit = tmo_q == TW'(BR_TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        irsrc   = IRSRC_PASS;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (lu) begin
                    irsrc   = IRSRC_NOP;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end else if (opcode_of(id_q) == OP_BNE) begin
                    irsrc   = IRSRC_BNE;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    state_d = BR_WAIT;
                    tmo_d   = '0;
                end
            end
            BR_WAIT: begin
                irsrc = IRSRC_NOP;
                if (bus.br_valid) begin
                    state_d = RUN;
                    flush   = bus.br_taken;
                end else if (tmo_hit) begin
                    // Give up on the branch: record it and resume as if not taken.
                    state_d = RUN;
                    err_d   = 1'b1;
                end else begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // While reset is held the control outputs already look like RUN with no hazard.
        if (rst) begin
            irsrc   = IRSRC_PASS;
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            flush   = 1'b0;
        end
    end

    assign id_d    = flush ? NOP : ifid_we ? (bus.if_valid ? bus.if_instr : NOP) : id_q;
    assign stall_d = (!pc_we && stall_q != '1) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tmo_q   <= '0;
            id_q    <= NOP;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            id_q    <= id_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.id_instr   = id_q;
    assign bus.irsrc_rf   = irsrc;
    assign bus.pc_write   = pc_we;
    assign bus.ifid_write = ifid_we;
    assign bus.stall_cnt  = stall_q;
    assign bus.br_err     = err_q;
endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb_if_id_hazard_ctrl: scoreboard bench with directed scenarios and random stimulus vs a reference model
module tb_if_id_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    if_id_hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();

    if_id_hazard_ctrl #(.BR_TIMEOUT(15), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  irsrc;
        logic        pc;
        logic        ifid;
        logic [31:0] id;
        logic [15:0] stall;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Reference model: pipeline bookkeeping kept as plain integers.
    bit          m_waiting;
    int          m_waited;
    logic [31:0] m_id;
    int          m_stalls;
    bit          m_err;

    function automatic logic [31:0] mk(input int op, input int rs, input int rt);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'($urandom)};
        return w;
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic iv,
                        input logic mr, input logic [4:0] xrt, input logic bv, input logic bt);
        exp_t e;
        bit hazard, take_if, flush;
        rst             = r;
        bus.if_instr    = ins;
        bus.if_valid    = iv;
        bus.ex_mem_read = mr;
        bus.ex_rt       = xrt;
        bus.br_valid    = bv;
        bus.br_taken    = bt;
        e.id    = m_id;
        e.stall = 16'(m_stalls);
        e.err   = m_err;
        take_if = 0;
        flush   = 0;
        if (r) begin
            e.irsrc = 2'd0; e.pc = 1; e.ifid = 1;
        end else if (!m_waiting) begin
            hazard = mr && xrt != 0 && (xrt == m_id[25:21] || xrt == m_id[20:16]);
            if (hazard) begin
                e.irsrc = 2'd1; e.pc = 0; e.ifid = 0;
            end else if (m_id[31:26] == 6'd5) begin
                e.irsrc = 2'd2; e.pc = 0; e.ifid = 0;
                m_waiting = 1; m_waited = 0;
            end else begin
                e.irsrc = 2'd0; e.pc = 1; e.ifid = 1; take_if = 1;
            end
        end else if (bv || m_waited == 14) begin
            e.irsrc = 2'd1; e.pc = 1; e.ifid = 1;
            m_waiting = 0;
            if (bv && bt) flush = 1;
            else take_if = 1;
            if (!bv) m_err = 1;
        end else begin
            e.irsrc = 2'd1; e.pc = 0; e.ifid = 0;
            m_waited++;
        end
        sb.push_back(e);
        if (r) begin
            m_waiting = 0; m_waited = 0; m_id = 0; m_stalls = 0; m_err = 0;
        end else begin
            if (flush) m_id = 0;
            else if (take_if) m_id = iv ? ins : 32'h0;
            if (!e.pc && m_stalls < 65535) m_stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] ins);
        step(0, ins, 1, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("irsrc_rf", 32'(bus.irsrc_rf), 32'(e.irsrc));
            chk("pc_write", 32'(bus.pc_write), 32'(e.pc));
            chk("ifid_write", 32'(bus.ifid_write), 32'(e.ifid));
            chk("id_instr", bus.id_instr, e.id);
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall));
            chk("br_err", 32'(bus.br_err), 32'(e.err));
        end
    end

    initial begin
        rst = 1;
        bus.if_instr = 0; bus.if_valid = 0; bus.ex_mem_read = 0;
        bus.ex_rt = 0; bus.br_valid = 0; bus.br_taken = 0;
        m_waiting = 0; m_waited = 0; m_id = 0; m_stalls = 0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        // load-use on rs=5 then release
        run(mk(0, 5, 7));
        step(0, mk(0, 1, 2), 1, 1, 5, 0, 0);
        run(mk(0, 1, 2));
        // load to r0 with rs=0 must not stall
        run(mk(0, 0, 3));
        step(0, mk(0, 2, 3), 1, 1, 0, 0, 0);
        // BNE taken on 3rd wait cycle
        run(mk(5, 1, 2));
        run(mk(0, 1, 2));
        step(0, mk(0, 1, 2), 1, 0, 0, 0, 1);
        step(0, mk(0, 1, 2), 1, 0, 0, 0, 0);
        step(0, mk(0, 1, 2), 1, 0, 0, 1, 1);
        run(mk(0, 3, 3));
        run(mk(0, 3, 3));
        // BNE not taken on 1st wait cycle; br_valid in RUN is ignored
        step(0, mk(5, 1, 2), 1, 0, 0, 1, 1);
        run(mk(0, 1, 2));
        step(0, mk(9, 4, 4), 1, 0, 0, 1, 0);
        run(mk(0, 1, 2));
        // timeout, then a later branch
        run(mk(5, 1, 2));
        run(mk(0, 1, 2));
        for (int i = 0; i < 15; i++) run(mk(0, 6, 6));
        run(mk(0, 1, 1));
        run(mk(5, 1, 2));
        run(mk(0, 1, 2));
        step(0, mk(0, 1, 2), 1, 0, 0, 1, 1);
        run(mk(0, 1, 2));
        // reset in the middle of BR_WAIT
        run(mk(5, 1, 2));
        run(mk(0, 1, 2));
        run(mk(0, 1, 2));
        step(1, mk(0, 1, 2), 1, 0, 0, 0, 0);
        run(mk(0, 1, 2));
        // stall counter saturation
        run(mk(0, 5, 9));
        for (int i = 0; i < 65540; i++) step(0, mk(0, 1, 2), 1, 1, 5, 0, 0);
        run(mk(0, 1, 2));
        step(1, mk(0, 1, 2), 1, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 mk(($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 63),
                    $urandom_range(0, 3), $urandom_range(0, 3)),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
